// File: rtl/ffcp_rx_reorder_buf.sv
// FFCP receive reorder buffer: captures payloads into per-index slots in any order within the
// receive window and replays completed payloads downstream strictly in index order.
module ffcp_rx_reorder_buf #(
  parameter int unsigned IndexLen   = 6,
  parameter int unsigned Slots      = 4,
  parameter int unsigned DataLen    = 769,
  parameter int unsigned RamLatency = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                syn_i,
  input  logic                in_metadata_clk_i,
  input  logic [IndexLen-1:0] in_index_i,
  input  logic                inclk_i,
  input  logic [7:0]          in_i,
  input  logic                in_done_i,
  input  logic                out_rdy_i,
  output logic                outclk_o,
  output logic [7:0]          out_o,
  output logic                out_done_o,
  output logic                commit_clk_o,
  output logic [IndexLen-1:0] commit_index_o,
  output logic [IndexLen-1:0] head_index_o
);
  localparam int unsigned SlotW = $clog2(Slots);
  localparam int unsigned CntW  = $clog2(DataLen);
  localparam int unsigned Depth = Slots * DataLen;
  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [CntW-1:0] LastCnt = CntW'(DataLen - 1);

  typedef enum logic [1:0] {WIdle, WWrite, WDrop} wstate_e;
  typedef enum logic [1:0] {RIdle, RStream, RDrain} rstate_e;

  wstate_e             wstate_q, wstate_d;
  rstate_e             rstate_q, rstate_d;
  logic [Slots-1:0]    valid_q, valid_d;
  logic [IndexLen-1:0] head_q, head_d;
  logic [IndexLen-1:0] widx_q, widx_d;
  logic [CntW-1:0]     wcnt_q, wcnt_d;
  logic [CntW-1:0]     rcnt_q, rcnt_d;
  logic                commit_clk_q, commit_clk_d;
  logic [IndexLen-1:0] commit_index_q, commit_index_d;
  logic [IndexLen-1:0] off;
  logic                wr_en, rd_en, rd_last, rd_done;
  logic [AddrW-1:0]    waddr, raddr;

  logic [7:0]            mem [Depth];
  logic [7:0]            pipe_data_q [RamLatency];
  logic [RamLatency-1:0] pipe_vld_q, pipe_last_q;

  assign waddr = AddrW'(DataLen) * AddrW'(widx_q[SlotW-1:0]) + AddrW'(wcnt_q);
  assign raddr = AddrW'(DataLen) * AddrW'(head_q[SlotW-1:0]) + AddrW'(rcnt_q);

  // Write side: a new metadata pulse always wins and re-evaluates against the current head.
  always_comb begin
    wstate_d       = wstate_q;
    widx_d         = widx_q;
    wcnt_d         = wcnt_q;
    wr_en          = 1'b0;
    commit_clk_d   = 1'b0;
    commit_index_d = commit_index_q;
    off            = in_index_i - head_q;
    if (in_metadata_clk_i) begin
      widx_d   = in_index_i;
      wcnt_d   = '0;
      wstate_d = (off < IndexLen'(Slots) && !valid_q[in_index_i[SlotW-1:0]]) ? WWrite : WDrop;
    end else begin
      unique case (wstate_q)
        WWrite: begin
          wr_en = inclk_i;
          if (in_done_i) begin
            wstate_d = WIdle;
            if (wcnt_q == LastCnt) begin
              commit_clk_d   = 1'b1;
              commit_index_d = widx_q;
            end
          end else if (inclk_i) begin
            if (wcnt_q == LastCnt) wstate_d = WDrop;
            else                   wcnt_d   = wcnt_q + 1'b1;
          end
        end
        WDrop:   if (in_done_i) wstate_d = WIdle;
        default: ;
      endcase
    end
  end

  // Read side: once started, one RAM read per cycle with no stalls.
  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    rd_en    = 1'b0;
    rd_done  = 1'b0;
    rd_last  = (rcnt_q == LastCnt);
    unique case (rstate_q)
      RIdle:   rd_en = valid_q[head_q[SlotW-1:0]] && out_rdy_i;
      RStream: rd_en = 1'b1;
      RDrain: begin
        if (pipe_last_q[RamLatency-1]) begin
          rd_done  = 1'b1;
          rstate_d = RIdle;
        end
      end
      default: ;
    endcase
    if (rd_en) begin
      if (rd_last) begin
        rstate_d = RDrain;
        rcnt_d   = '0;
      end else begin
        rstate_d = RStream;
        rcnt_d   = rcnt_q + 1'b1;
      end
    end
  end

  // Set and clear never hit the same slot: writes into valid slots are refused.
  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    if (commit_clk_d) valid_d[widx_q[SlotW-1:0]] = 1'b1;
    if (rd_done) begin
      valid_d[head_q[SlotW-1:0]] = 1'b0;
      head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || syn_i) begin
      wstate_q       <= WIdle;
      rstate_q       <= RIdle;
      valid_q        <= '0;
      head_q         <= '0;
      widx_q         <= '0;
      wcnt_q         <= '0;
      rcnt_q         <= '0;
      commit_clk_q   <= 1'b0;
      commit_index_q <= '0;
    end else begin
      wstate_q       <= wstate_d;
      rstate_q       <= rstate_d;
      valid_q        <= valid_d;
      head_q         <= head_d;
      widx_q         <= widx_d;
      wcnt_q         <= wcnt_d;
      rcnt_q         <= rcnt_d;
      commit_clk_q   <= commit_clk_d;
      commit_index_q <= commit_index_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= in_i;
  end

  always_ff @(posedge clk) begin
    if (rst || syn_i) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      for (int i = 0; i < int'(RamLatency); i++) pipe_data_q[i] <= '0;
    end else begin
      pipe_vld_q[0]  <= rd_en;
      pipe_last_q[0] <= rd_en & rd_last;
      pipe_data_q[0] <= rd_en ? mem[raddr] : 8'h00;
      for (int i = 1; i < int'(RamLatency); i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  assign outclk_o       = pipe_vld_q[RamLatency-1];
  assign out_o          = pipe_data_q[RamLatency-1];
  assign out_done_o     = pipe_last_q[RamLatency-1];
  assign commit_clk_o   = commit_clk_q;
  assign commit_index_o = commit_index_q;
  assign head_index_o   = head_q;

endmodule
